mips_bus_arbiter: RTL and testbench
===================================

Name: mips_bus_arbiter

Overview:
- Two-master, one-slave arbiter for the CPU's Avalon-style memory bus (address/read/write/waitrequest/writedata/byteenable/readdata).
- Lets the CPU (m0) and a second requester (m1: debug loader or DMA) share the single memory-side bus that feeds the address-decoded RAM regions.
- Uses round-robin grant, forwards waitrequest to the granted master only, and runs a stall watchdog on slave waitrequest.

Parameters:
- TIMEOUT_CYCLES, 1024: consecutive slave-waitrequest-high cycles on one granted transfer before err_timeout is set.
- FIRST_PRIORITY, 0: master favoured on the first simultaneous request after reset (0 or 1).

Ports:
- clk input 1: rising-edge clock.
- reset_n input 1: asynchronous, active-low reset.
- m0_address input 32: CPU word address.
- m0_read input 1: CPU read request.
- m0_write input 1: CPU write request.
- m0_writedata input 32: CPU write data.
- m0_byteenable input 4: CPU byte lanes.
- m0_waitrequest output 1: stall to the CPU.
- m0_readdata output 32: read data to the CPU.
- m1_address input 32, m1_read input 1, m1_write input 1, m1_writedata input 32, m1_byteenable input 4: same as m0, for master 1.
- m1_waitrequest output 1, m1_readdata output 32: same as m0, for master 1.
- s_address output 32, s_read output 1, s_write output 1, s_writedata output 32, s_byteenable output 4: to the memory decode.
- s_waitrequest input 1: stall from memory.
- s_readdata input 32: read data from memory.
- grant output 2: one-hot current owner ({m1,m0}); 00 when idle.
- err_timeout output 1: sticky stall error.

Behaviour:
- Request definition: req_x = mx_read | mx_write. Read and write asserted together by one master is illegal; the arbiter forwards both unchanged.
- States (in package): IDLE, GRANT0, GRANT1. State is registered, so grant is always registered.
- Reset (async, reset_n=0):
  - state=IDLE, grant=00, err_timeout=0, watchdog=0, priority pointer=FIRST_PRIORITY.
  - s_read=s_write=0; s_address, s_writedata, s_byteenable=0.
  - m0_waitrequest=m1_waitrequest=1.
- Reset asserted mid-transfer aborts the transfer immediately. No completion is reported to either master.
- IDLE:
  - s_read=s_write=0; both mx_waitrequest=1.
  - One request: next state GRANTx.
  - Both requests: grant the pointer's master.
  - No requests: stay in IDLE.
  - Latency from first request cycle to grant: 1 clk.
- GRANTx:
  - s_* outputs = master x's signals, combinationally.
  - mx_waitrequest = s_waitrequest; the other master's waitrequest = 1.
- Transfer completes on a rising edge where req_x=1 and s_waitrequest=0. On completion:
  - Pointer moves to the other master.
  - Next state is GRANTother if the other master requests in that cycle; else GRANTx if req_x stays 1; else IDLE.
  - This gives strict alternation under contention and back-to-back transfers for a lone master with zero idle cycles.
- Granted master drops its request without completing (protocol violation): next state IDLE, pointer unchanged.
- readdata: s_readdata is broadcast to both m0_readdata and m1_readdata. It is meaningful only to the granted master, in its waitrequest-low cycle.
- Watchdog:
  - Counter is cleared on completion, on state change, and in IDLE.
  - Increments each GRANTx cycle with s_waitrequest=1, saturating at TIMEOUT_CYCLES.
  - Reaching TIMEOUT_CYCLES sets err_timeout, which stays set until reset.
  - No abort: the transfer continues to wait.
  - Counter width is clog2(TIMEOUT_CYCLES+1).
- Simultaneous new request from the other master in the completion cycle: it is honoured next cycle, with no bubble.
- Slave waitrequest low while in IDLE: ignored.

Decomposition:
- Package mips_bus_pkg:
  - arb_state_t enum (IDLE, GRANT0, GRANT1).
  - Master index constants M_CPU=0, M_AUX=1.
  - Bus width constants ADDR_W=32, DATA_W=32, BE_W=4.
- Sub-module mips_bus_watchdog:
  - Parameter TIMEOUT_CYCLES.
  - Inputs clk, reset_n, clear, stall; output err (sticky).
  - Instantiated once.

Test Plan:
- Reset: hold reset_n=0 with m0_read=1 -> grant=00, s_read=0, m0_waitrequest=1, err_timeout=0; release reset -> grant=01 one clk later.
- Lone master back-to-back: m0_read at 0xBFC00000 and 0xBFC00004, s_waitrequest=0 -> two completions in 2 consecutive granted cycles, no IDLE between, s_address matches each.
- Contention alternation: m0 and m1 both read continuously, s_waitrequest random 1–6 cycles -> grant sequence 01,10,01,10…; each master sees waitrequest=0 only while granted; m1_waitrequest=1 throughout m0 transfers.
- Write passthrough: m1_write=1 at addr 0x00000010, writedata=0xDEADBEEF, byteenable=0011 under grant 10 -> s_* mirror exactly; m0 held off until completion.
- Watchdog: TIMEOUT_CYCLES=8, s_waitrequest stuck at 1 -> err_timeout rises after 8 stall cycles and stays 1 after s_waitrequest falls; transfer then completes normally.
- Abandoned request: m0_read drops after 2 stalled cycles -> next state IDLE, grant=00, pointer unchanged, so a following simultaneous request is granted to m0 again.

Source files
------------

// File: rtl/mips_bus_pkg.sv
// Shared types and constants for the MIPS memory-bus arbiter.
//   arb_state_t : arbiter FSM states (IDLE, GRANT0, GRANT1)
//   M_CPU/M_AUX : master indices (m0 = CPU, m1 = debug loader / DMA)
//   ADDR_W/DATA_W/BE_W : Avalon-style bus widths
package mips_bus_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        GRANT0 = 2'd1,
        GRANT1 = 2'd2
    } arb_state_t;

    localparam int M_CPU  = 0;
    localparam int M_AUX  = 1;

    localparam int ADDR_W = 32;
    localparam int DATA_W = 32;
    localparam int BE_W   = 4;

endpackage

// File: rtl/mips_bus_watchdog.sv
// Stall watchdog for the arbitrated slave bus.
//   clk, reset_n : clock, async active-low reset
//   clear        : zero the stall counter (idle, completion, owner change)
//   stall        : granted transfer is being held off by the slave this cycle
//   err          : sticky, set once TIMEOUT_CYCLES consecutive stalls are seen
// The watchdog only reports; it never aborts the transfer.
module mips_bus_watchdog #(
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic clk,
    input  logic reset_n,
    input  logic clear,
    input  logic stall,
    output logic err
);

    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CW-1:0] LIMIT = CW'(TIMEOUT_CYCLES);

    logic [CW-1:0] cnt_q, cnt_d;
    logic          err_q, err_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clear)
            cnt_d = '0;
        else if (stall && (cnt_q != LIMIT))
            cnt_d = cnt_q + 1'b1;   // saturate at the limit
        // err follows the counter's next value so it rises on the edge that
        // closes the TIMEOUT_CYCLES-th stall cycle.
        err_d = err_q | (cnt_d == LIMIT);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q <= '0;
            err_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            err_q <= err_d;
        end
    end

    assign err = err_q;

endmodule

// File: rtl/mips_bus_arbiter.sv
// Two-master / one-slave round-robin arbiter for the CPU memory bus.
//   clk, reset_n           : clock, async active-low reset
//   m0_* / m1_*            : Avalon-style master ports (CPU, aux loader/DMA)
//   s_*                    : slave port toward the memory decode
//   grant                  : registered one-hot owner {m1,m0}, 00 when idle
//   err_timeout            : sticky slave-stall error from the watchdog
// The granted master's signals pass combinationally to the slave; the other
// master is held off with waitrequest. The priority pointer flips to the
// other master on every completion, giving strict alternation under load.
module mips_bus_arbiter
    import mips_bus_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 1024,
    parameter int FIRST_PRIORITY = 0
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [ADDR_W-1:0] m0_address,
    input  logic              m0_read,
    input  logic              m0_write,
    input  logic [DATA_W-1:0] m0_writedata,
    input  logic [BE_W-1:0]   m0_byteenable,
    output logic              m0_waitrequest,
    output logic [DATA_W-1:0] m0_readdata,
    input  logic [ADDR_W-1:0] m1_address,
    input  logic              m1_read,
    input  logic              m1_write,
    input  logic [DATA_W-1:0] m1_writedata,
    input  logic [BE_W-1:0]   m1_byteenable,
    output logic              m1_waitrequest,
    output logic [DATA_W-1:0] m1_readdata,
    output logic [ADDR_W-1:0] s_address,
    output logic              s_read,
    output logic              s_write,
    output logic [DATA_W-1:0] s_writedata,
    output logic [BE_W-1:0]   s_byteenable,
    input  logic              s_waitrequest,
    input  logic [DATA_W-1:0] s_readdata,
    output logic [1:0]        grant,
    output logic              err_timeout
);

    arb_state_t state_q, state_d;
    logic       ptr_q, ptr_d;      // master favoured on the next tie
    logic       req0, req1;
    logic       complete;

    assign req0 = m0_read | m0_write;
    assign req1 = m1_read | m1_write;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            ptr_q   <= (FIRST_PRIORITY != 0);
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
        end
    end

    always_comb begin
        state_d        = state_q;
        ptr_d          = ptr_q;
        complete       = 1'b0;
        s_address      = '0;
        s_read         = 1'b0;
        s_write        = 1'b0;
        s_writedata    = '0;
        s_byteenable   = '0;
        m0_waitrequest = 1'b1;
        m1_waitrequest = 1'b1;

        unique case (state_q)
            IDLE: begin
                if (req0 && req1)
                    state_d = ptr_q ? GRANT1 : GRANT0;
                else if (req0)
                    state_d = GRANT0;
                else if (req1)
                    state_d = GRANT1;
            end
            GRANT0: begin
                s_address      = m0_address;
                s_read         = m0_read;
                s_write        = m0_write;
                s_writedata    = m0_writedata;
                s_byteenable   = m0_byteenable;
                m0_waitrequest = s_waitrequest;
                if (req0 && !s_waitrequest) begin
                    complete = 1'b1;
                    ptr_d    = 1'(M_AUX);
                    // hand over without a bubble if m1 is waiting, else keep
                    // m0 for a back-to-back transfer
                    state_d  = req1 ? GRANT1 : GRANT0;
                end else if (!req0) begin
                    state_d  = IDLE;   // abandoned; pointer untouched
                end
            end
            GRANT1: begin
                s_address      = m1_address;
                s_read         = m1_read;
                s_write        = m1_write;
                s_writedata    = m1_writedata;
                s_byteenable   = m1_byteenable;
                m1_waitrequest = s_waitrequest;
                if (req1 && !s_waitrequest) begin
                    complete = 1'b1;
                    ptr_d    = 1'(M_CPU);
                    state_d  = req0 ? GRANT0 : GRANT1;
                end else if (!req1) begin
                    state_d  = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign grant       = {state_q == GRANT1, state_q == GRANT0};
    assign m0_readdata = s_readdata;
    assign m1_readdata = s_readdata;

    mips_bus_watchdog #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_watchdog (
        .clk     (clk),
        .reset_n (reset_n),
        .clear   ((state_q == IDLE) | complete | (state_d != state_q)),
        .stall   ((state_q != IDLE) & s_waitrequest),
        .err     (err_timeout)
    );

endmodule

// File: tb/tb_mips_bus_arbiter.sv
// Self-checking bench for mips_bus_arbiter: directed steps plus randomized
// contention, checked every cycle against an owner/pointer reference model.
module tb_mips_bus_arbiter;

    localparam int TO = 8;

    logic        clk, reset_n;
    logic [31:0] m0_address, m0_writedata, m1_address, m1_writedata;
    logic        m0_read, m0_write, m1_read, m1_write;
    logic [3:0]  m0_byteenable, m1_byteenable;
    logic        m0_waitrequest, m1_waitrequest;
    logic [31:0] m0_readdata, m1_readdata;
    logic [31:0] s_address, s_writedata, s_readdata;
    logic        s_read, s_write, s_waitrequest;
    logic [3:0]  s_byteenable;
    logic [1:0]  grant;
    logic        err_timeout;

    mips_bus_arbiter #(.TIMEOUT_CYCLES(TO), .FIRST_PRIORITY(0)) dut (
        .clk(clk), .reset_n(reset_n),
        .m0_address(m0_address), .m0_read(m0_read), .m0_write(m0_write),
        .m0_writedata(m0_writedata), .m0_byteenable(m0_byteenable),
        .m0_waitrequest(m0_waitrequest), .m0_readdata(m0_readdata),
        .m1_address(m1_address), .m1_read(m1_read), .m1_write(m1_write),
        .m1_writedata(m1_writedata), .m1_byteenable(m1_byteenable),
        .m1_waitrequest(m1_waitrequest), .m1_readdata(m1_readdata),
        .s_address(s_address), .s_read(s_read), .s_write(s_write),
        .s_writedata(s_writedata), .s_byteenable(s_byteenable),
        .s_waitrequest(s_waitrequest), .s_readdata(s_readdata),
        .grant(grant), .err_timeout(err_timeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // reference model: owner 0 = nobody, 1 = m0, 2 = m1; fav = tie winner
    int owner, fav, stall_run;
    bit err_m;
    int dut_done_m;   // master seen completing this cycle (-1 none)

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        owner = 0; fav = 0; stall_run = 0; err_m = 0;
    endtask

    task automatic check_outputs();
        logic [31:0] ea, ed; logic er, ew; logic [3:0] eb; logic w0, w1; logic [1:0] eg;
        ea = 0; ed = 0; er = 0; ew = 0; eb = 0; w0 = 1; w1 = 1; eg = 2'b00;
        if (owner == 1) begin
            eg = 2'b01; ea = m0_address; ed = m0_writedata; er = m0_read;
            ew = m0_write; eb = m0_byteenable; w0 = s_waitrequest;
        end else if (owner == 2) begin
            eg = 2'b10; ea = m1_address; ed = m1_writedata; er = m1_read;
            ew = m1_write; eb = m1_byteenable; w1 = s_waitrequest;
        end
        chk("grant", 32'(grant), 32'(eg));
        chk("s_address", s_address, ea);
        chk("s_writedata", s_writedata, ed);
        chk("s_read", 32'(s_read), 32'(er));
        chk("s_write", 32'(s_write), 32'(ew));
        chk("s_byteenable", 32'(s_byteenable), 32'(eb));
        chk("m0_waitrequest", 32'(m0_waitrequest), 32'(w0));
        chk("m1_waitrequest", 32'(m1_waitrequest), 32'(w1));
        chk("m0_readdata", m0_readdata, s_readdata);
        chk("m1_readdata", m1_readdata, s_readdata);
        chk("err_timeout", 32'(err_timeout), 32'(err_m));
    endtask

    // One clock: check this cycle's outputs, advance model, cross the edge.
    task automatic tick();
        bit want[2]; int nxt, x; bit done;
        #1;
        check_outputs();
        want[0] = m0_read | m0_write;
        want[1] = m1_read | m1_write;
        dut_done_m = -1;
        if (!m0_waitrequest && want[0]) dut_done_m = 0;
        if (!m1_waitrequest && want[1]) dut_done_m = 1;
        nxt = owner; done = 0;
        if (owner == 0) begin
            if (want[0] && want[1]) nxt = fav + 1;
            else if (want[0]) nxt = 1;
            else if (want[1]) nxt = 2;
        end else begin
            x = owner - 1;
            if (want[x] && !s_waitrequest) begin
                done = 1;
                fav  = 1 - x;
                nxt  = want[1 - x] ? (2 - x) : owner;
            end else if (!want[x]) begin
                nxt = 0;
            end
        end
        if (owner == 0 || done || nxt != owner) stall_run = 0;
        else if (s_waitrequest && stall_run < TO) stall_run++;
        if (stall_run == TO) err_m = 1;
        @(posedge clk);
        #1;
        owner = nxt;
    endtask

    initial begin
        int prev_m, ncomp, run;
        bit r;
        reset_n = 0;
        m0_address = 0; m0_writedata = 0; m0_read = 1; m0_write = 0; m0_byteenable = 4'hF;
        m1_address = 0; m1_writedata = 0; m1_read = 0; m1_write = 0; m1_byteenable = 4'hF;
        s_waitrequest = 0; s_readdata = 32'h1234_5678;
        model_reset();

        // ---- reset with a pending request
        repeat (2) @(posedge clk);
        #1;
        chk("rst_grant", 32'(grant), 0);
        chk("rst_s_read", 32'(s_read), 0);
        chk("rst_m0_wait", 32'(m0_waitrequest), 1);
        chk("rst_err", 32'(err_timeout), 0);
        reset_n = 1;
        tick();
        chk("grant_after_release", 32'(grant), 32'h1);

        // ---- lone master back-to-back
        m0_address = 32'hBFC0_0000;
        tick();                       // first completion
        chk("b2b_grant_kept", 32'(grant), 32'h1);
        m0_address = 32'hBFC0_0004;
        #1;
        chk("b2b_addr2", s_address, 32'hBFC0_0004);
        tick();                       // second completion, no idle between
        m0_read = 0;
        tick();
        chk("lone_idle", 32'(grant), 0);

        // ---- m1 write passthrough while m0 waits (pointer now favours m1)
        m1_write = 1; m1_address = 32'h10; m1_writedata = 32'hDEAD_BEEF; m1_byteenable = 4'b0011;
        m0_read = 1; m0_address = 32'h8000_0000;
        s_waitrequest = 1;
        tick();
        chk("wr_grant", 32'(grant), 32'h2);
        #1;
        chk("wr_s_addr", s_address, 32'h10);
        chk("wr_s_data", s_writedata, 32'hDEAD_BEEF);
        chk("wr_s_be", 32'(s_byteenable), 32'b0011);
        chk("wr_m0_held", 32'(m0_waitrequest), 1);
        tick(); tick();
        s_waitrequest = 0;
        tick();                       // m1 completes, m0 granted with no bubble
        m1_write = 0;
        chk("handover_grant", 32'(grant), 32'h1);

        // ---- m0 abandons after two stalled cycles
        s_waitrequest = 1;
        tick(); tick();
        m0_read = 0;
        tick();
        chk("abandon_idle", 32'(grant), 0);
        m0_read = 1; m1_read = 1;
        tick();
        chk("abandon_ptr_kept", 32'(grant), 32'h1);

        // ---- randomized contention: completions must alternate
        prev_m = -1; ncomp = 0; run = 0;
        for (int i = 0; i < 160; i++) begin
            r = $urandom_range(0, 1) != 0; m0_read = r; m0_write = !r;
            r = $urandom_range(0, 1) != 0; m1_read = r; m1_write = !r;
            m0_address = $urandom; m0_writedata = $urandom; m0_byteenable = 4'($urandom);
            m1_address = $urandom; m1_writedata = $urandom; m1_byteenable = 4'($urandom);
            s_readdata = $urandom;
            s_waitrequest = (run >= 5) ? 1'b0 : ($urandom_range(0, 1) != 0);
            run = s_waitrequest ? run + 1 : 0;
            tick();
            if (dut_done_m >= 0) begin
                if (prev_m >= 0) chk("alternation", 32'(dut_done_m), 32'(1 - prev_m));
                prev_m = dut_done_m;
                ncomp++;
            end
        end
        chk("contention_completions", 32'(ncomp > 20), 1);
        m0_read = 0; m0_write = 0; m1_read = 0; m1_write = 0; s_waitrequest = 0;
        tick(); tick();
        chk("contention_idle", 32'(grant), 0);

        // ---- watchdog: stuck slave
        chk("wd_err_clean", 32'(err_timeout), 0);
        m0_read = 1; s_waitrequest = 1;
        tick();                       // grant
        repeat (TO - 1) tick();
        chk("wd_err_before", 32'(err_timeout), 0);
        tick();
        chk("wd_err_set", 32'(err_timeout), 1);
        tick(); tick();
        s_waitrequest = 0;
        #1;
        chk("wd_m0_released", 32'(m0_waitrequest), 0);
        tick();
        m0_read = 0;
        tick();
        chk("wd_err_sticky", 32'(err_timeout), 1);
        chk("wd_idle", 32'(grant), 0);

        // ---- reset mid-transfer aborts at once
        m1_read = 1; s_waitrequest = 1;
        tick();
        chk("mid_grant", 32'(grant), 32'h2);
        reset_n = 0;
        #1;
        chk("mid_rst_grant", 32'(grant), 0);
        chk("mid_rst_m1_wait", 32'(m1_waitrequest), 1);
        chk("mid_rst_s_read", 32'(s_read), 0);
        chk("mid_rst_err", 32'(err_timeout), 0);
        m1_read = 0; s_waitrequest = 0;
        @(posedge clk); #1;
        reset_n = 1;
        model_reset();
        tick(); tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
